// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce and single-cycle press strobe
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   row[3:0]  keypad rows, active-low, externally pulled up
//   col[3:0]  column drive, active-low, one bit low at a time
//   key_code  last committed key {row_idx, col_idx}
//   key_valid one-cycle strobe when key_code is (re)issued
//   key_down  high while a debounced key is held
// Build option: define KEYPAD_SCAN_REPEAT_EN for auto-repeat (adds REPEAT_DELAY/REPEAT_RATE).
module keypad_scan #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 10
`ifdef KEYPAD_SCAN_REPEAT_EN
  ,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam int TW = $clog2(SCAN_TICKS);
  typedef enum logic {UP, DOWN} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick;
  logic [1:0] col_idx;
  logic [3:0] row_m, row_s;
  logic [15:0] snap;
  logic scan_end, last;
  logic [4:0] n_set;
  logic [3:0] idx, code, code_n;
  logic present, same, accepted, down_n, valid_n;
  logic prev_present;
  logic [3:0] prev_code;
  logic [7:0] stable_cnt, cnt_n;
`ifdef KEYPAD_SCAN_REPEAT_EN
  logic [15:0] rep_cnt, rep_n;
  logic rep_phase, phase_n;
`endif
  assign last = tick == TW'(SCAN_TICKS - 1);
  assign col = ~(4'b0001 << col_idx);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tick <= '0;
      col_idx <= 2'd0;
      row_m <= 4'hF;
      row_s <= 4'hF;
      snap <= 16'h0;
      scan_end <= 1'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      scan_end <= last && col_idx == 2'd3;
      if (last) begin
        tick <= '0;
        col_idx <= col_idx + 2'd1;
        snap[{col_idx, 2'b00} +: 4] <= ~row_s;
      end else
        tick <= tick + TW'(1);
    end
  // snap bit index is {col_idx,row_idx}; key code swaps the halves
  always_comb begin
    n_set = 5'd0;
    idx = 4'd0;
    for (int i = 0; i < 16; i++)
      if (snap[i]) begin
        n_set = n_set + 5'd1;
        idx = 4'(i);
      end
    present = n_set == 5'd1;
    code = present ? {idx[1:0], idx[3:2]} : 4'd0;
    same = {present, code} == {prev_present, prev_code};
    cnt_n = !same ? 8'd1 : stable_cnt == 8'(DEBOUNCE_SCANS) ? stable_cnt : stable_cnt + 8'd1;
    accepted = cnt_n == 8'(DEBOUNCE_SCANS);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      prev_present <= 1'b0;
      prev_code <= 4'd0;
      stable_cnt <= 8'd0;
    end else if (scan_end) begin
      prev_present <= present;
      prev_code <= code;
      stable_cnt <= cnt_n;
    end
  always_comb begin
    state_n = state;
    code_n = key_code;
    down_n = key_down;
    valid_n = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
    rep_n = rep_cnt;
    phase_n = rep_phase;
`endif
    if (scan_end && accepted) begin
      if (present && (state == UP || code != key_code)) begin
        state_n = DOWN;
        code_n = code;
        down_n = 1'b1;
        valid_n = 1'b1;
`ifdef KEYPAD_SCAN_REPEAT_EN
        rep_n = 16'd0;
        phase_n = 1'b0;
`endif
      end else if (!present && state == DOWN) begin
        state_n = UP;
        down_n = 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
        rep_n = 16'd0;
        phase_n = 1'b0;
`endif
      end
`ifdef KEYPAD_SCAN_REPEAT_EN
      // first repeat after REPEAT_DELAY held scans, then every REPEAT_RATE
      else if (present && state == DOWN) begin
        valid_n = rep_cnt + 16'd1 == (rep_phase ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY));
        rep_n = valid_n ? 16'd0 : rep_cnt + 16'd1;
        phase_n = rep_phase | valid_n;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= UP;
      key_code <= 4'd0;
      key_down <= 1'b0;
      key_valid <= 1'b0;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_cnt <= 16'd0;
      rep_phase <= 1'b0;
`endif
    end else begin
      state <= state_n;
      key_code <= code_n;
      key_down <= down_n;
      key_valid <= valid_n;
`ifdef KEYPAD_SCAN_REPEAT_EN
      rep_cnt <= rep_n;
      rep_phase <= phase_n;
`endif
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized and directed scan-level checking of keypad_scan against a key-set model
module tb_keypad_scan;
  localparam int ST = 4, DEB = 2, RD = 3, RR = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid, key_down;
  logic [15:0] pressed = 16'h0;
  int checks = 0, errors = 0;
  logic [4:0] hist[$];
  logic m_down, exp_v;
  logic [3:0] m_code;
  int m_rep;
  logic [15:0] prev_keys;
  bit have_prev;
  always #5 clk = ~clk;
  keypad_scan #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DEB)
`ifdef KEYPAD_SCAN_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
`endif
  ) dut (.clk(clk), .reset(reset), .row(row), .col(col), .key_code(key_code),
         .key_valid(key_valid), .key_down(key_down));
  // physical keypad: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 16; c++)
      if (pressed[c] && !col[c % 4]) row[c / 4] = 1'b0;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] k(input int c);
    logic [15:0] one = 16'h1;
    return one << c;
  endfunction
  task automatic model_reset();
    hist.delete();
    m_down = 1'b0;
    m_code = 4'd0;
    m_rep = 0;
    have_prev = 0;
  endtask
  // one full scan of a constant key set: decode, debounce over the last DEB scans, commit
  task automatic model_step(input logic [15:0] keys);
    logic [4:0] p = 5'd0;
    bit acc;
    if ($countones(keys) == 1)
      for (int c = 0; c < 16; c++) if (keys[c]) p = {1'b1, 4'(c)};
    hist.push_back(p);
    if (hist.size() > DEB) void'(hist.pop_front());
    acc = hist.size() == DEB;
    foreach (hist[i]) if (hist[i] != p) acc = 0;
    exp_v = 1'b0;
    if (acc) begin
      if (p[4] && (!m_down || p[3:0] != m_code)) begin
        exp_v = 1'b1;
        m_down = 1'b1;
        m_code = p[3:0];
        m_rep = 0;
      end else if (!p[4] && m_down) begin
        m_down = 1'b0;
        m_rep = 0;
      end else if (p[4]) begin
        m_rep++;
`ifdef KEYPAD_SCAN_REPEAT_EN
        exp_v = m_rep == RD || (m_rep > RD && (m_rep - RD) % RR == 0);
`endif
      end
    end
  endtask
  // window of one scan: the previous scan's result shows up at its start
  task automatic do_scan(input logic [15:0] keys);
    int nv = 0;
    logic [3:0] vcode = 4'd0, ec;
    exp_v = 1'b0;
    if (have_prev) model_step(prev_keys);
    pressed = keys;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      ec = ~(4'b0001 << ((i / 4) % 4));
      chk("col", col, ec);
      if (key_valid) begin
        nv++;
        vcode = key_code;
      end
    end
    chk("strobes", 16'(nv), {15'd0, exp_v});
    if (exp_v) chk("strobe_code", vcode, m_code);
    chk("key_down", key_down, m_down);
    chk("key_code", key_code, m_code);
    prev_keys = keys;
    have_prev = 1;
  endtask
  task automatic hold(input logic [15:0] keys, input int n);
    repeat (n) do_scan(keys);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("rst_col", col, 4'hE);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_down", key_down, 1'b0);
    chk("rst_code", key_code, 4'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask
  initial begin
    logic [15:0] ks;
    int a, b;
    model_reset();
    do_reset();
    hold(16'h0, 2);
    hold(k(9), 5);
    hold(16'h0, 3);
    hold(k(5), 1);
    hold(16'h0, 3);
    hold(k(0) | k(15), 3);
    hold(16'h0, 2);
    hold(k(0), 3);
    hold(k(0) | k(15), 3);
    hold(16'h0, 2);
    hold(k(3), 3);
    hold(k(12), 3);
    hold(16'h0, 3);
    hold(k(7), 10);
    hold(16'h0, 3);
    hold(k(6), 3);
    do_reset();
    hold(k(6), 4);
    hold(16'h0, 3);
    for (int s = 0; s < 40; s++) begin
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: ks = 16'h0;
        3: ks = (a == b) ? k(a) | k((a + 1) % 16) : k(a) | k(b);
        default: ks = k(a);
      endcase
      hold(ks, $urandom_range(1, 5));
      if (s == 20) do_reset();
    end
    hold(16'h0, 3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
